// File: rtl/ct_pkg.sv
// Shared definitions for the CT/PT sample scalers: FSM encoding, default gain
// and the channel-index width helper.
package ct_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [15:0] GAIN_DEF_CT = 16'h0900;

  // A single-channel build still needs a 1-bit channel index.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_scale_sat.sv
// Combinational output stage: logical right shift of an unsigned product,
// saturation to the output magnitude range, sign re-attach with no negative zero.
module sm_scale_sat #(
  parameter int PROD_W = 31,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 4
) (
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_sign,
  output logic [OUT_W-1:0]  o_out,
  output logic              o_sat
);

  // Zero-extend so the limit compare works whatever PROD_W is relative to OUT_W.
  localparam int EW = PROD_W + OUT_W;
  localparam logic [EW-1:0] LIM = (EW'(1) << (OUT_W - 1)) - EW'(1);

  logic [EW-1:0]    w_m;
  logic [OUT_W-2:0] w_mag;

  assign w_m   = {{OUT_W{1'b0}}, i_prod} >> SHIFT;
  assign o_sat = (w_m > LIM);
  assign w_mag = o_sat ? {(OUT_W-1){1'b1}} : w_m[OUT_W-2:0];
  assign o_out = {i_sign & (|w_mag), w_mag};

endmodule

// File: rtl/ct_scale_mc.sv
// Multi-channel CT/PT sample scaler: captures NCH sign-magnitude samples on a
// start request and streams gain-scaled, shifted, saturated results one per cycle.
module ct_scale_mc import ct_pkg::*; #(
  parameter int                NCH      = 3,
  parameter int                IN_W     = 16,
  parameter int                GAIN_W   = 16,
  parameter int                OUT_W    = 24,
  parameter int                SHIFT    = 4,
  parameter logic [GAIN_W-1:0] GAIN_DEF = GAIN_W'(GAIN_DEF_CT),
  localparam int               CW       = ch_w(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NCH*IN_W-1:0] a,
  input  logic                gain_wr,
  input  logic [CW-1:0]       gain_ch,
  input  logic [GAIN_W-1:0]   gain_data,
  output logic [OUT_W-1:0]    out,
  output logic [CW-1:0]       out_ch,
  output logic                out_valid,
  output logic                sat,
  output logic                busy,
  output logic                done
);

  localparam int PROD_W = IN_W - 1 + GAIN_W;

  logic [1:0]          r_state;
  logic [CW-1:0]       r_ch;
  logic [NCH*IN_W-1:0] r_samp;
  logic [GAIN_W-1:0]   r_gain [NCH];

  logic                r_s1_valid;
  logic                r_s1_sign;
  logic                r_s1_last;
  logic [CW-1:0]       r_s1_ch;
  logic [PROD_W-1:0]   r_s1_prod;

  logic [IN_W-1:0]     w_samp;
  logic                w_last;
  logic [OUT_W-1:0]    w_out;
  logic                w_sat;

  assign w_samp = r_samp[r_ch*IN_W +: IN_W];
  assign w_last = (r_ch == CW'(NCH - 1));
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_samp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_samp  <= a;
            r_ch    <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_ch <= r_ch + 1'b1;
          if (w_last) r_state <= S_FLUSH;
        end
        // Leave FLUSH on the same edge that stage 2 emits the last channel.
        S_FLUSH: begin
          if (r_s1_valid && r_s1_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gains are frozen during a frame; out-of-range channel indices never match.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n) begin
        r_gain[i] <= GAIN_DEF;
      end else if (gain_wr && !busy && (gain_ch == CW'(i))) begin
        r_gain[i] <= gain_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_prod  <= '0;
    end else begin
      r_s1_valid <= (r_state == S_RUN);
      r_s1_sign  <= w_samp[IN_W-1];
      r_s1_last  <= w_last;
      r_s1_ch    <= r_ch;
      r_s1_prod  <= PROD_W'(w_samp[IN_W-2:0]) * PROD_W'(r_gain[r_ch]);
    end
  end

  sm_scale_sat #(
    .PROD_W (PROD_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_scale_sat (
    .i_prod (r_s1_prod),
    .i_sign (r_s1_sign),
    .o_out  (w_out),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      done      <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        out    <= w_out;
        out_ch <= r_s1_ch;
        sat    <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_ct_scale_mc.sv
// Bench for ct_scale_mc: NCH=3 instance driven through a scoreboard, plus an
// NCH=1 instance checked cycle by cycle.
module tb_ct_scale_mc;

  localparam int NCH   = 3;
  localparam int CW    = 2;
  localparam int OUT_W = 24;
  localparam int REC_W = OUT_W + CW + 2;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [47:0]       a;
  logic              gain_wr;
  logic [CW-1:0]     gain_ch;
  logic [15:0]       gain_data;
  logic [OUT_W-1:0]  out;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              sat;
  logic              busy;
  logic              done;

  logic              en1;
  logic [15:0]       a1;
  logic              gain_wr1;
  logic [0:0]        gain_ch1;
  logic [15:0]       gain_data1;
  logic [OUT_W-1:0]  out1;
  logic [0:0]        out_ch1;
  logic              out_valid1;
  logic              sat1;
  logic              busy1;
  logic              done1;

  int n_checks = 0;
  int n_fail   = 0;

  // Record layout: {done, sat, out_ch, out}
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] obs_q[$];
  logic [15:0]      m_gain [NCH];

  ct_scale_mc #(.NCH(NCH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .a         (a),
    .gain_wr   (gain_wr),
    .gain_ch   (gain_ch),
    .gain_data (gain_data),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .sat       (sat),
    .busy      (busy),
    .done      (done)
  );

  ct_scale_mc #(.NCH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en1),
    .a         (a1),
    .gain_wr   (gain_wr1),
    .gain_ch   (gain_ch1),
    .gain_data (gain_data1),
    .out       (out1),
    .out_ch    (out_ch1),
    .out_valid (out_valid1),
    .sat       (sat1),
    .busy      (busy1),
    .done      (done1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) obs_q.push_back({done, sat, out_ch, out});
  end

  // ---------------- model ----------------
  function automatic logic [24:0] model(input logic [15:0] s, input logic [15:0] g);
    logic [30:0] p;
    logic [30:0] m;
    logic [22:0] mag;
    logic        st;
    p  = 31'(s[14:0]) * 31'(g);
    m  = p >> 4;
    st = (m > 31'h7FFFFF);
    mag = st ? 23'h7FFFFF : m[22:0];
    return {st, s[15] && (mag != 23'd0), mag};
  endfunction

  task automatic push_frame(input logic [47:0] samp);
    logic [24:0] r;
    for (int i = 0; i < NCH; i++) begin
      r = model(samp[i*16 +: 16], m_gain[i]);
      exp_q.push_back({(i == NCH - 1), r[24], CW'(i), r[23:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 20 && busy; t++) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b still set after 20 cycles, required 0", busy);
    end
  endtask

  task automatic start_frame(input logic [47:0] samp);
    a  = samp;
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_idle();
  endtask

  task automatic write_gain(input logic [CW-1:0] ch, input logic [15:0] g);
    gain_wr   = 1'b1;
    gain_ch   = ch;
    gain_data = g;
    tick();
    gain_wr   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks += 7;
    if (out !== 24'h0)       begin n_fail++; $display("FAIL reset_out: got %h, required 000000", out); end
    if (out_ch !== 2'd0)     begin n_fail++; $display("FAIL reset_out_ch: got %0d, required 0", out_ch); end
    if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (sat !== 1'b0)        begin n_fail++; $display("FAIL reset_sat: got %b, required 0", sat); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    if (busy1 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy1: got %b, required 0", busy1); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_default();
    logic [REC_W-1:0] e, o;
    exp_q.push_back({1'b0, 1'b0, 2'd0, 24'h009000});
    exp_q.push_back({1'b0, 1'b0, 2'd1, 24'h809000});
    exp_q.push_back({1'b1, 1'b0, 2'd2, 24'h000000});
    start_frame({16'h0000, 16'h8100, 16'h0100});
    for (int t = 0; t < 40 && obs_q.size() < exp_q.size(); t++) tick();
    tick(); tick();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL default_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL default_out: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturation();
    logic [REC_W-1:0] e, o;
    write_gain(2'd0, 16'hFFFF); m_gain[0] = 16'hFFFF;
    exp_q.push_back({1'b0, 1'b1, 2'd0, 24'h7FFFFF});
    exp_q.push_back({1'b0, 1'b0, 2'd1, 24'h800090});
    exp_q.push_back({1'b1, 1'b0, 2'd2, 24'h000000});
    start_frame({16'h0000, 16'h8001, 16'h7FFF});
    exp_q.push_back({1'b0, 1'b1, 2'd0, 24'hFFFFFF});
    exp_q.push_back({1'b0, 1'b0, 2'd1, 24'h000000});
    exp_q.push_back({1'b1, 1'b0, 2'd2, 24'h000000});
    start_frame({16'h0000, 16'h0000, 16'hFFFF});
    write_gain(2'd0, 16'h0900); m_gain[0] = 16'h0900;
    exp_q.push_back({1'b0, 1'b0, 2'd0, 24'h47FF70});
    exp_q.push_back({1'b0, 1'b0, 2'd1, 24'h000000});
    exp_q.push_back({1'b1, 1'b0, 2'd2, 24'hC7FF70});
    start_frame({16'hFFFF, 16'h8000, 16'h7FFF});
    for (int t = 0; t < 40 && obs_q.size() < exp_q.size(); t++) tick();
    tick(); tick();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL sat_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL sat_out: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [REC_W-1:0] e, o;
    logic [7:0]  eb, ev, ed;
    logic [47:0] s1, s2;
    eb = 8'b1110_1111;
    ev = 8'b1001_1100;
    ed = 8'b0001_0000;
    s1 = {16'h1234, 16'h8ABC, 16'h0F0F};
    s2 = {16'h8001, 16'h7000, 16'h0042};
    push_frame(s1);
    push_frame(s2);
    a  = s1;
    en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 5) a = s2;
      tick();
      if (j == 5) en = 1'b0;
      n_checks += 3;
      if (busy !== eb[j])      begin n_fail++; $display("FAIL b2b_busy edge k+%0d: got %b, required %b", j, busy, eb[j]); end
      if (out_valid !== ev[j]) begin n_fail++; $display("FAIL b2b_valid edge k+%0d: got %b, required %b", j, out_valid, ev[j]); end
      if (done !== ed[j])      begin n_fail++; $display("FAIL b2b_done edge k+%0d: got %b, required %b", j, done, ed[j]); end
    end
    for (int t = 0; t < 40 && obs_q.size() < exp_q.size(); t++) tick();
    tick(); tick();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_out: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_gain_busy();
    logic [REC_W-1:0] e, o;
    logic [47:0] s;
    s = {16'h0321, 16'h0200, 16'h8100};
    push_frame(s);
    a  = s;
    en = 1'b1;
    tick();
    en = 1'b0;
    write_gain(2'd0, 16'h1234);
    wait_idle();
    push_frame(s);
    start_frame(s);
    write_gain(2'd3, 16'h0001);
    push_frame(s);
    start_frame(s);
    // gain write in the same IDLE cycle as en lands first
    m_gain[2] = 16'h4000;
    s = {16'h8123, 16'h0010, 16'h0001};
    push_frame(s);
    a = s; en = 1'b1; gain_wr = 1'b1; gain_ch = 2'd2; gain_data = 16'h4000;
    tick();
    en = 1'b0; gain_wr = 1'b0;
    wait_idle();
    for (int t = 0; t < 40 && obs_q.size() < exp_q.size(); t++) tick();
    tick(); tick();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL gain_busy_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL gain_busy_out: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [REC_W-1:0] e, o;
    logic [47:0] s;
    int n_done;
    write_gain(2'd1, 16'h2000);
    s = {16'h0100, 16'h8100, 16'h0100};
    a  = s;
    en = 1'b1;
    tick();
    en    = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL rstmid_done: got %b, required 0", done); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    obs_q.delete();
    n_done = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (done || out_valid) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin n_fail++; $display("FAIL rstmid_stray: got %0d cycles with done/out_valid, required 0", n_done); end
    for (int i = 0; i < NCH; i++) m_gain[i] = 16'h0900;
    push_frame(s);
    start_frame(s);
    for (int t = 0; t < 40 && obs_q.size() < exp_q.size(); t++) tick();
    tick(); tick();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rstmid_out: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [REC_W-1:0] e, o;
    logic [47:0] s;
    logic [1:0]  ch;
    logic [15:0] g;
    for (int f = 0; f < 6; f++) begin
      ch = 2'($urandom_range(0, 2));
      g  = 16'($urandom_range(0, 16'hFFFF));
      write_gain(ch, g);
      m_gain[ch] = g;
      s = {16'($urandom), 16'($urandom), 16'($urandom)};
      push_frame(s);
      start_frame(s);
    end
    for (int t = 0; t < 40 && obs_q.size() < exp_q.size(); t++) tick();
    tick(); tick();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random_out: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_nch1();
    logic [15:0] samp [2];
    logic [23:0] want [2];
    samp[0] = 16'h0100; want[0] = 24'h009000;
    samp[1] = 16'h8000; want[1] = 24'h000000;
    gain_wr1 = 1'b1; gain_ch1 = 1'b1; gain_data1 = 16'hFFFF;
    tick();
    gain_wr1 = 1'b0;
    for (int f = 0; f < 2; f++) begin
      a1  = samp[f];
      en1 = 1'b1;
      tick();
      en1 = 1'b0;
      tick();
      n_checks += 2;
      if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL nch1_early_valid: got %b, required 0", out_valid1); end
      if (busy1 !== 1'b1)      begin n_fail++; $display("FAIL nch1_busy: got %b, required 1", busy1); end
      tick();
      n_checks += 5;
      if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL nch1_valid: got %b, required 1", out_valid1); end
      if (done1 !== 1'b1)      begin n_fail++; $display("FAIL nch1_done: got %b, required 1", done1); end
      if (out1 !== want[f])    begin n_fail++; $display("FAIL nch1_out: got %h, required %h", out1, want[f]); end
      if (out_ch1 !== 1'b0)    begin n_fail++; $display("FAIL nch1_out_ch: got %0d, required 0", out_ch1); end
      if (sat1 !== 1'b0)       begin n_fail++; $display("FAIL nch1_sat: got %b, required 0", sat1); end
      tick();
      n_checks += 2;
      if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL nch1_valid_drop: got %b, required 0", out_valid1); end
      if (done1 !== 1'b0)      begin n_fail++; $display("FAIL nch1_done_drop: got %b, required 0", done1); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; a = '0; gain_wr = 1'b0; gain_ch = '0; gain_data = '0;
    en1 = 1'b0; a1 = '0; gain_wr1 = 1'b0; gain_ch1 = '0; gain_data1 = '0;
    for (int i = 0; i < NCH; i++) m_gain[i] = 16'h0900;
    test_reset();
    test_default();
    test_saturation();
    test_back_to_back();
    test_gain_busy();
    test_reset_mid();
    test_random();
    test_nch1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_scale_mc.md
Name: ct_scale_mc

Overview:
- Multi-channel successor to the single-channel CT sample scaler.
- Scales NCH sign-magnitude CT/PT samples by per-channel programmable gains, then shifts right and saturates.
- Captures all channels on one start request and streams the results out one channel per cycle. Signals frame completion with a done pulse.
- Sits between the ADC sample capture and the power-quality computation blocks.

Parameters:
- NCH, 3, number of channels (≥1).
- IN_W, 16, input sample width (sign bit = MSB, magnitude IN_W-1 bits).
- GAIN_W, 16, unsigned gain width.
- OUT_W, 24, output width (sign bit = MSB, magnitude OUT_W-1 bits).
- SHIFT, 4, right shift applied to the product.
- GAIN_DEF, 16'h0900, reset value of every gain register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  start request; sampled only in IDLE.
- a  in  NCH*IN_W  packed samples; channel i occupies bits [i*IN_W +: IN_W].
- gain_wr  in  1  gain register write strobe.
- gain_ch  in  CW  channel index for the gain write, where CW = max(1, clog2(NCH)).
- gain_data  in  GAIN_W  gain value to write.
- out  out  OUT_W  scaled sign-magnitude result.
- out_ch  out  CW  channel index of the value on out.
- out_valid  out  1  out and out_ch are valid this cycle.
- sat  out  1  the current result was clipped; qualified by out_valid.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse coinciding with the last channel's out_valid.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - out, out_ch, out_valid, sat, busy and done all go to 0.
  - All gain registers go to GAIN_DEF.
  - The pipeline is flushed. Reset mid-frame abandons the frame, and no done pulse is issued.
- FSM states:
  - IDLE: if en=1, latch all NCH samples, set ch=0, go to RUN. Otherwise stay in IDLE.
  - RUN: issue the latched sample of channel ch into stage 1 and increment ch. After issuing ch=NCH-1, go to FLUSH.
  - FLUSH: wait for stage 2 to emit the last channel, then go to IDLE.
  - en is ignored in any state other than IDLE.
- Pipeline:
  - Stage 1 registers the sign and the product mag_in*gain[ch], where mag_in = sample[IN_W-2:0] and the product is (IN_W-1+GAIN_W) bits wide.
  - Stage 2 registers out, out_ch, out_valid and sat.
- Latency, with en accepted at edge k:
  - Channel i is valid at edge k+2+i.
  - done=1 together with channel NCH-1 at edge k+1+NCH.
  - busy is high from edge k+1 through edge k+1+NCH inclusive.
  - A new en is accepted at the earliest on the edge after done, so frames are back-to-back with one IDLE cycle between them.
- Arithmetic:
  - m = product >> SHIFT (logical shift).
  - If m > 2^(OUT_W-1)-1: magnitude = all ones and sat=1. Otherwise magnitude = m[OUT_W-2:0] and sat=0.
  - out = {sign, magnitude}, where sign is the sample MSB of the same channel (never a stale value).
  - If the magnitude is zero, the sign is forced to 0 (no negative zero).
- Gain writes:
  - Applied at the edge only while busy=0; ignored while busy=1.
  - A gain_ch value ≥ NCH is ignored.
  - A gain write and en in the same IDLE cycle: the write lands first, and the frame uses the new gain.
- out and out_ch hold their last value when out_valid=0.

Decomposition:
- Shared package ct_pkg holds:
  - the FSM state encoding (S_IDLE, S_RUN, S_FLUSH);
  - GAIN_DEF_CT = 16'h0900;
  - a channel-index width helper function.
- One sub-module: sm_scale_sat, the combinational stage-2 logic (shift, saturate, sign and zero handling), parametrised by widths and SHIFT. It is reused by future PT scalers.

Test Plan:
1. Default gains, NCH=3:
   - Stimulus: a = {16'h0000, 16'h8100, 16'h0100}, en pulse.
   - Response: out = 24'h009000 (ch0), 24'h809000 (ch1), 24'h000000 (ch2, sign forced 0), one per cycle, with out_ch = 0, 1, 2.
   - done coincides with ch2; sat stays 0.
2. Saturation:
   - Stimulus: write gain[0] = 16'hFFFF; a ch0 = 16'h7FFF, then 16'hFFFF.
   - Response: out = 24'h7FFFFF with sat=1, then 24'hFFFFFF with sat=1.
   - Boundary: gain = 16'h0900 with a = 16'h7FFF → out = 24'h47FF70, sat=0.
3. Latency and handshake:
   - en accepted at edge k → out_valid at k+2..k+4; busy high k+1..k+4.
   - en held high throughout → the next frame is accepted at k+5 and its first out_valid appears at k+7.
4. Gain write while busy:
   - gain_wr during RUN → ignored; the following frame still uses the old gain.
   - gain_wr with gain_ch=3 → no register changes.
5. Reset mid-frame:
   - rst_n=0 one cycle after acceptance → the next edge shows out_valid=0, done=0, busy=0, and gains back to 16'h0900.
   - No stray done pulse afterwards.
6. NCH=1 build:
   - Single channel; out_valid and done both assert at k+2; CW=1.
